// File: rtl/fir_fxp_pkg.sv
// Fixed-point constants and round/saturate helpers shared by the FIR output stages.
// Default format: FIR result 22 bits (8.10 plus 4 growth bits), sample 9 bits (4.5).
package fir_fxp_pkg;

  localparam int unsigned WIX = 4;    // sample integer bits (sign included)
  localparam int unsigned WFX = 5;    // sample fractional bits
  localparam int unsigned WIO = 8;    // FIR result integer bits before growth
  localparam int unsigned WFO = 10;   // FIR result fractional bits
  localparam int unsigned N   = 4;    // accumulator growth bits

  localparam int unsigned IW = WIO + WFO + N;  // FIR result width
  localparam int unsigned OW = WIX + WFX;      // sample width
  localparam int unsigned SH = WFO - WFX;      // fractional bits dropped

  localparam logic signed [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};

  // Round half toward +inf and drop sh fractional bits; y must be sign-extended to 64 bits.
  function automatic logic signed [64:0] fxp_round(input logic signed [63:0] y,
                                                   input int unsigned sh);
    logic signed [64:0] ext;
    ext = {y[63], y};
    if (sh > 0) begin
      ext = ext + (65'sd1 <<< (sh - 1));
      ext = ext >>> sh;
    end
    return ext;
  endfunction

  // True when the rounded value falls outside an ow-bit signed range.
  function automatic logic fxp_clips(input logic signed [63:0] y,
                                     input int unsigned sh,
                                     input int unsigned ow);
    logic signed [64:0] r;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    r  = fxp_round(y, sh);
    hi = (65'sd1 <<< (ow - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (ow - 1));
    return (r > hi) || (r < lo);
  endfunction

  // Rounded value clamped to an ow-bit signed range (ow <= 32), returned sign-extended.
  function automatic logic signed [31:0] fxp_requant(input logic signed [63:0] y,
                                                     input int unsigned sh,
                                                     input int unsigned ow);
    logic signed [64:0] r;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    r  = fxp_round(y, sh);
    hi = (65'sd1 <<< (ow - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (ow - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return 32'(r);
  endfunction

endpackage

// File: rtl/fir_requant_fifo.sv
// Small synchronous FIFO with a registered head word.
// Ports: clk/rst (sync, active-high); push_* write side (push_ready = not full);
// pop_* read side (pop_valid = not empty, pop_data = registered head); level = occupancy.
module fir_requant_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  input  logic [DW-1:0]              push_data,
  output logic                       push_ready,
  output logic [DW-1:0]              pop_data,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] head_q, head_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;
  logic          push_c;
  logic          pop_c;

  // Next-state: pointer/level update and head prefetch for the entry that will be at the front.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    push_c   = push_valid & ready_q;
    pop_c    = valid_q & pop_ready;

    if (push_c) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_c && !pop_c) begin
      level_d = level_q + LW'(1);
    end else if (!push_c && pop_c) begin
      level_d = level_q - LW'(1);
    end

    // New front entry may be the word being written this very cycle.
    if (level_d != '0) begin
      if (push_c && (wr_ptr_q == rd_ptr_d)) begin
        head_d = push_data;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end

    valid_d = (level_d != '0);
    ready_d = (level_d != LW'(DEPTH));
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign push_ready = ready_q;
  assign pop_data   = head_q;
  assign pop_valid  = valid_q;
  assign level      = level_q;

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantizer: rounds/saturates full-precision results to the sample format,
// buffers them in a FIFO and tracks saturation.
// Ports: CLK/RESET (sync, active-high); Y_IN/IN_VALID/IN_READY input handshake;
// X_OUT/OUT_VALID/OUT_READY output handshake; SAT_FLAG pulse, SAT_STICKY, SAT_CNT; LEVEL occupancy.
module fir_out_requant
  import fir_fxp_pkg::*;
#(
  parameter int unsigned WIX   = fir_fxp_pkg::WIX,
  parameter int unsigned WFX   = fir_fxp_pkg::WFX,
  parameter int unsigned WIO   = fir_fxp_pkg::WIO,
  parameter int unsigned WFO   = fir_fxp_pkg::WFO,
  parameter int unsigned N     = fir_fxp_pkg::N,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [WIO+WFO+N-1:0]       Y_IN,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  output logic [WIX+WFX-1:0]         X_OUT,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic                       SAT_FLAG,
  output logic                       SAT_STICKY,
  output logic [CW-1:0]              SAT_CNT,
  output logic [$clog2(DEPTH):0]     LEVEL
);

  localparam int unsigned OW_L = WIX + WFX;
  localparam int unsigned SH_L = WFO - WFX;

  logic [OW_L-1:0] sample_c;
  logic            clip_c;
  logic            push_c;
  logic            sat_flag_q, sat_flag_d;
  logic            sat_sticky_q, sat_sticky_d;
  logic [CW-1:0]   sat_cnt_q, sat_cnt_d;

  // Requantize the incoming result; only matters on the cycle it is pushed.
  always_comb begin
    sample_c = OW_L'(fxp_requant(64'($signed(Y_IN)), SH_L, OW_L));
    clip_c   = fxp_clips(64'($signed(Y_IN)), SH_L, OW_L);
    push_c   = IN_VALID & IN_READY;
  end

  fir_requant_fifo #(
    .DEPTH (DEPTH),
    .DW    (OW_L)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RESET),
    .push_valid (IN_VALID),
    .push_data  (sample_c),
    .push_ready (IN_READY),
    .pop_data   (X_OUT),
    .pop_valid  (OUT_VALID),
    .pop_ready  (OUT_READY),
    .level      (LEVEL)
  );

  // Saturation accounting over accepted samples only; counter holds at all-ones.
  always_comb begin
    sat_flag_d   = push_c & clip_c;
    sat_sticky_d = sat_sticky_q | (push_c & clip_c);
    sat_cnt_d    = sat_cnt_q;
    if (push_c && clip_c && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sat_flag_q   <= 1'b0;
      sat_sticky_q <= 1'b0;
      sat_cnt_q    <= '0;
    end else begin
      sat_flag_q   <= sat_flag_d;
      sat_sticky_q <= sat_sticky_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  assign SAT_FLAG   = sat_flag_q;
  assign SAT_STICKY = sat_sticky_q;
  assign SAT_CNT    = sat_cnt_q;

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: vector table for the arithmetic, hand sequences
// for backpressure, concurrent push/pop, reset and counter saturation.
module tb_fir_out_requant;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [21:0] Y_IN;
  logic        IN_VALID;
  logic        IN_READY;
  logic [8:0]  X_OUT;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        SAT_FLAG;
  logic        SAT_STICKY;
  logic [15:0] SAT_CNT;
  logic [2:0]  LEVEL;

  // Second instance with a 3-bit counter to reach the counter ceiling quickly.
  logic        s_in_ready;
  logic [8:0]  s_x_out;
  logic        s_out_valid;
  logic        s_sat_flag;
  logic        s_sat_sticky;
  logic [2:0]  s_sat_cnt;
  logic [2:0]  s_level;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fir_out_requant dut (
    .CLK(CLK), .RESET(RESET), .Y_IN(Y_IN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .X_OUT(X_OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .SAT_FLAG(SAT_FLAG),
    .SAT_STICKY(SAT_STICKY), .SAT_CNT(SAT_CNT), .LEVEL(LEVEL)
  );

  fir_out_requant #(.CW(3)) dut_small (
    .CLK(CLK), .RESET(RESET), .Y_IN(Y_IN), .IN_VALID(IN_VALID), .IN_READY(s_in_ready),
    .X_OUT(s_x_out), .OUT_VALID(s_out_valid), .OUT_READY(OUT_READY), .SAT_FLAG(s_sat_flag),
    .SAT_STICKY(s_sat_sticky), .SAT_CNT(s_sat_cnt), .LEVEL(s_level)
  );

  typedef struct {
    logic [21:0] y;
    logic [8:0]  x;
    logic        clip;
  } vec_t;

  function automatic vec_t mk(input int y, input int x, input bit clip);
    vec_t v;
    v.y    = 22'(y);
    v.x    = 9'(x);
    v.clip = clip;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  vec_t vecs[13];
  int   exp_cnt;
  logic [8:0] got[$];

  initial begin
    RESET = 1'b1; Y_IN = '0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    step(); step();
    RESET = 1'b0;

    // Reset state
    chk("rst_level", 32'(LEVEL), 0);
    chk("rst_out_valid", 32'(OUT_VALID), 0);
    chk("rst_in_ready", 32'(IN_READY), 1);
    chk("rst_x_out", 32'(X_OUT), 0);
    chk("rst_sat_flag", 32'(SAT_FLAG), 0);
    chk("rst_sat_sticky", 32'(SAT_STICKY), 0);
    chk("rst_sat_cnt", 32'(SAT_CNT), 0);

    // Arithmetic vectors: y raw (Q.10), expected sample raw (Q.5), expected clip.
    vecs[0]  = mk(1536, 48, 0);
    vecs[1]  = mk(16, 1, 0);
    vecs[2]  = mk(-16, 0, 0);
    vecs[3]  = mk(-17, -1, 0);
    vecs[4]  = mk(15, 0, 0);
    vecs[5]  = mk(102400, 255, 1);
    vecs[6]  = mk(-102400, -256, 1);
    vecs[7]  = mk(8176, 255, 1);
    vecs[8]  = mk(8160, 255, 0);
    vecs[9]  = mk(-8192, -256, 0);
    vecs[10] = mk(-8208, -256, 0);
    vecs[11] = mk(-8209, -256, 1);
    vecs[12] = mk(0, 0, 0);

    exp_cnt = 0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 13; i++) begin
      Y_IN = vecs[i].y;
      IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      if (vecs[i].clip) exp_cnt++;
      chk($sformatf("vec%0d_out_valid", i), 32'(OUT_VALID), 1);
      chk($sformatf("vec%0d_x_out", i), 32'(X_OUT), 32'(vecs[i].x));
      chk($sformatf("vec%0d_sat_flag", i), 32'(SAT_FLAG), 32'(vecs[i].clip));
      chk($sformatf("vec%0d_sat_cnt", i), 32'(SAT_CNT), 32'(exp_cnt));
      chk($sformatf("vec%0d_sat_sticky", i), 32'(SAT_STICKY), 32'(exp_cnt > 0));
      step();
      chk($sformatf("vec%0d_flag_clear", i), 32'(SAT_FLAG), 0);
      chk($sformatf("vec%0d_drained", i), 32'(LEVEL), 0);
    end

    // Backpressure: four pushes fill the FIFO, the fifth is held off.
    OUT_READY = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      Y_IN = 22'(k * 1024);
      IN_VALID = 1'b1;
      step();
    end
    chk("bp_in_ready_full", 32'(IN_READY), 0);
    chk("bp_level_full", 32'(LEVEL), 4);
    Y_IN = 22'(5 * 1024);
    step(); step();
    chk("bp_level_held", 32'(LEVEL), 4);
    chk("bp_head_held", 32'(X_OUT), 32);
    OUT_READY = 1'b1;
    got.delete();
    for (int t = 0; t < 30 && got.size() < 5; t++) begin
      automatic logic will_push = IN_VALID & IN_READY;
      if (OUT_VALID) got.push_back(X_OUT);
      step();
      if (will_push) IN_VALID = 1'b0;
      if (t == 0) chk("bp_no_flow_through", 32'(LEVEL), 3);
    end
    chk("bp_count", 32'(got.size()), 5);
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      chk($sformatf("bp_order%0d", k), 32'(got[k]), 32'(32 * (k + 1)));
    end
    step();
    chk("bp_empty", 32'(OUT_VALID), 0);

    // Concurrent push/pop at level 2: samples 1..12 (raw y = 32*v -> x = v).
    OUT_READY = 1'b0;
    for (int v = 1; v <= 2; v++) begin
      Y_IN = 22'(32 * v);
      IN_VALID = 1'b1;
      step();
    end
    chk("pp_level_start", 32'(LEVEL), 2);
    OUT_READY = 1'b1;
    got.delete();
    for (int v = 3; v <= 12; v++) begin
      Y_IN = 22'(32 * v);
      got.push_back(X_OUT);
      step();
      chk($sformatf("pp_level_c%0d", v), 32'(LEVEL), 2);
    end
    IN_VALID = 1'b0;
    for (int t = 0; t < 10 && OUT_VALID; t++) begin
      got.push_back(X_OUT);
      step();
    end
    chk("pp_count", 32'(got.size()), 12);
    for (int k = 0; k < 12 && k < got.size(); k++) begin
      chk($sformatf("pp_order%0d", k), 32'(got[k]), 32'(k + 1));
    end
    step();
    chk("pop_empty_level", 32'(LEVEL), 0);
    chk("pop_empty_valid", 32'(OUT_VALID), 0);
    chk("pop_empty_ready", 32'(IN_READY), 1);

    // Reset mid-stream with three buffered samples and one more clip counted.
    OUT_READY = 1'b0;
    Y_IN = 22'(102400); IN_VALID = 1'b1; step();
    Y_IN = 22'(1536); step();
    step();
    chk("mid_level", 32'(LEVEL), 3);
    chk("mid_sat_cnt", 32'(SAT_CNT), 5);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    IN_VALID = 1'b0;
    chk("mr_level", 32'(LEVEL), 0);
    chk("mr_out_valid", 32'(OUT_VALID), 0);
    chk("mr_sat_cnt", 32'(SAT_CNT), 0);
    chk("mr_sat_sticky", 32'(SAT_STICKY), 0);
    chk("mr_in_ready", 32'(IN_READY), 1);
    step();
    chk("mr_dropped", 32'(LEVEL), 0);

    // Burst of nine clipped samples through a draining FIFO.
    OUT_READY = 1'b1;
    Y_IN = 22'(102400);
    IN_VALID = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 4) chk("burst_flag", 32'(SAT_FLAG), 1);
    end
    IN_VALID = 1'b0;
    chk("burst_cnt", 32'(SAT_CNT), 9);
    chk("burst_small_cnt_ceiling", 32'(s_sat_cnt), 7);
    chk("burst_small_sticky", 32'(s_sat_sticky), 1);
    chk("burst_x_out", 32'(X_OUT), 255);
    step(); step();
    chk("burst_drained", 32'(LEVEL), 0);

    // Accepts normally after all of the above.
    Y_IN = 22'(1536); IN_VALID = 1'b1; step(); IN_VALID = 1'b0;
    chk("post_x_out", 32'(X_OUT), 48);
    chk("post_out_valid", 32'(OUT_VALID), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
- Consumer-side stage for the FIR output bus.
- Accepts full-precision signed fixed-point filter results (WIO+N integer bits, WFO fractional bits) over a valid/ready handshake.
- Rounds and saturates each result back to the sample format (WIX.WFX), buffers it in a small FIFO, and hands it downstream over valid/ready.
- Reports saturation events. Sits between the FIR datapath and any sample sink or DAC interface.

Parameters:
- WIX, 4, integer bits of output sample (sign included)
- WFX, 5, fractional bits of output sample
- WIO, 8, integer bits of FIR result before growth (sign included)
- WFO, 10, fractional bits of FIR result; must satisfy WFO >= WFX
- N, 4, accumulator growth bits; input width = WIO+WFO+N
- DEPTH, 4, FIFO entries; power of two, >= 2
- CW, 16, saturation counter width

Ports:
- CLK, input, 1: single clock, all state on posedge.
- RESET, input, 1: synchronous, active-high.
- Y_IN, input, WIO+WFO+N: signed FIR result, two's complement.
- IN_VALID, input, 1: Y_IN valid.
- IN_READY, output, 1: block can accept; equals FIFO not full.
- X_OUT, output, WIX+WFX: requantized signed sample at FIFO head.
- OUT_VALID, output, 1: X_OUT valid; equals FIFO not empty.
- OUT_READY, input, 1: downstream accepts.
- SAT_FLAG, output, 1: one-cycle pulse, the cycle after an accepted sample was clipped.
- SAT_STICKY, output, 1: set on any clip; cleared only by RESET.
- SAT_CNT, output, CW: count of clipped samples; holds at all-ones (no wrap).
- LEVEL, output, clog2(DEPTH)+1: FIFO occupancy.

Behaviour:
- Reset: when RESET=1 at a posedge, then after that edge:
  - FIFO pointers and LEVEL = 0; OUT_VALID=0; IN_READY=1.
  - X_OUT=0; SAT_FLAG=0; SAT_STICKY=0; SAT_CNT=0.
  - Reset mid-operation discards all buffered samples; an in-flight accept in the reset cycle is dropped.
- Accept: push when IN_VALID & IN_READY at a posedge. Pop when OUT_VALID & OUT_READY.
- Push and pop in the same cycle is allowed when 0 < LEVEL < DEPTH; LEVEL is then unchanged.
- No flow-through: when full, IN_READY=0 even if a pop occurs that cycle.
- Arithmetic (combinational on Y_IN, result written to FIFO on push):
  - SH = WFO-WFX. Sign-extend Y_IN by 1 bit.
  - If SH>0, add 2^(SH-1) (round half toward +inf), then arithmetic shift right by SH.
  - If SH=0, pass through unchanged.
  - Compare against [-2^(WIX+WFX-1), 2^(WIX+WFX-1)-1]; clamp to the bound if outside and mark clip.
  - Defaults give an output range of raw -256..255, i.e. -8.0..7.96875.
- Latency:
  - Sample pushed into an empty FIFO at edge k appears on X_OUT with OUT_VALID=1 during cycle k+1.
  - X_OUT and OUT_VALID are registered; X_OUT holds its value while OUT_VALID=1 and OUT_READY=0.
- Order: strict FIFO. Read and write pointers wrap modulo DEPTH; the extra LEVEL bit distinguishes full from empty.
- Saturation accounting:
  - Only pushed samples count; non-accepted IN_VALID cycles are ignored.
  - SAT_CNT increments by 1 per clipped push and saturates at 2^CW-1.
- OUT_VALID=0: X_OUT holds its last value (0 after reset); the bench must not check it.

Decomposition:
- Shared package/header fir_fxp_pkg:
  - width constants: input width, output width, SH;
  - output min/max constants;
  - round/saturate function, reusable by other FIR variants.
- Sub-module fir_requant_fifo (DEPTH x (WIX+WFX), registered head, LEVEL output).
- The top holds the requantizer and saturation counters.

Test Plan:
- Basic: Y_IN=1536 (1.5), OUT_READY=1 → X_OUT=48 (1.5) one cycle after push; SAT_FLAG=0.
- Rounding: Y_IN=16 (+half LSB) → X_OUT=1; Y_IN=-16 → 0; Y_IN=-17 → -1; Y_IN=15 → 0.
- Saturation:
  - Y_IN=102400 (100.0) → X_OUT=255, SAT_FLAG pulse, SAT_CNT=1.
  - Y_IN=-102400 → X_OUT=-256 (9'h100), SAT_CNT=2, SAT_STICKY=1.
  - Y_IN=8176 (rounds to 256) → 255, SAT_CNT=3.
- Backpressure: OUT_READY=0, push 5 samples 1..5 (x32 scaling) → after 4 pushes IN_READY=0 and LEVEL=4; 5th held off. OUT_READY=1 → outputs 32,64,96,128,160 in order, no loss or duplicate.
- Simultaneous push/pop at LEVEL=2 for 10 cycles → LEVEL stays 2, order preserved. Pop at LEVEL=0 → no change.
- Reset mid-stream: LEVEL=3, SAT_CNT=5, RESET=1 for one cycle → next cycle LEVEL=0, OUT_VALID=0, SAT_CNT=0, SAT_STICKY=0, IN_READY=1.
